hazard_scoreboard: RTL and testbench

Parametrised next-generation pipeline hazard unit for the in-order RISC-V core. It sits beside the ID stage and keeps a registered shadow of in-flight destination registers for a configurable number of downstream stages. From that shadow it decides issue/stall and flush, freezes on multi-cycle data-memory accesses, and optionally selects forwarding sources. It also keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/hazard_scoreboard_pkg.sv | 31 +++
 rtl/hazard_scoreboard_if.sv | 40 ++++
 rtl/hazard_scoreboard_match.sv | 32 +++
 rtl/hazard_scoreboard.sv | 120 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared entry type, widths and constants for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int STAGES_DEF   = 3;
    localparam int REG_W        = $clog2(NUM_REGS_DEF);
    localparam int FWD_W        = $clog2(STAGES_DEF + 1);

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             is_load;
    } scoreboard_entry_t;

    localparam scoreboard_entry_t ENTRY_NONE = '0;

    function automatic scoreboard_entry_t make_entry(input logic [REG_W-1:0] rd,
                                                     input logic wr,
                                                     input logic is_load);
        scoreboard_entry_t e;
        e.valid   = 1'b1;
        e.rd      = rd;
        e.wr      = wr;
        e.is_load = is_load;
        return e;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-side request and hazard-decision signals of the scoreboard
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int STAGES   = 3,
    parameter int CNT_W    = 32
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int FW = $clog2(STAGES + 1);

    logic          id_valid_i;
    logic [RW-1:0] id_rs1_i;
    logic [RW-1:0] id_rs2_i;
    logic          id_rs1_used_i;
    logic          id_rs2_used_i;
    logic [RW-1:0] id_rd_i;
    logic          id_rd_wr_i;
    logic          id_is_load_i;
    logic          redirect_i;
    logic          dmem_busy_i;

    logic             issue_o;
    logic             stall_o;
    logic [STAGES:0]  flush_o;
    logic [FW-1:0]    fwd_rs1_o;
    logic [FW-1:0]    fwd_rs2_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_i, id_rd_wr_i, id_is_load_i, redirect_i, dmem_busy_i,
        input  issue_o, stall_o, flush_o, fwd_rs1_o, fwd_rs2_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_i, id_rd_wr_i, id_is_load_i, redirect_i, dmem_busy_i,
        output issue_o, stall_o, flush_o, fwd_rs1_o, fwd_rs2_o, stall_cnt_o
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// rtl/hazard_scoreboard_match.sv - youngest in-flight writer of one source register
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int RW     = REG_W,
    parameter int IDX_W  = 2
) (
    input  scoreboard_entry_t [STAGES-1:0] entries,
    input  logic [RW-1:0]                  src,
    input  logic                           used,
    output logic                           hit,
    output logic [IDX_W-1:0]               idx,
    output logic                           is_load
);

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].wr && (entries[k].rd == src)
                && (src != REG_ZERO) && used) begin
                hit     = 1'b1;
                idx     = IDX_W'(k);
                is_load = entries[k].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-order pipeline hazard unit; HAZARD_SCOREBOARD_FORWARDING_EN enables forwarding-aware stalls
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS      = NUM_REGS_DEF,
    parameter int STAGES        = STAGES_DEF,
    parameter int RESOLVE_STAGE = 1,
    parameter int CNT_W         = 32
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    hazard_scoreboard_if.slave bus
);

    localparam int RW    = $clog2(NUM_REGS);
    localparam int FW    = $clog2(STAGES + 1);
    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    scoreboard_entry_t [STAGES-1:0] sb_q;
    scoreboard_entry_t [STAGES-1:0] sb_kept;
    scoreboard_entry_t [STAGES-1:0] sb_d;
    logic [CNT_W-1:0]               cnt_q;

    logic             rs1_hit, rs2_hit;
    logic             rs1_ld, rs2_ld;
    logic [IDX_W-1:0] rs1_idx, rs2_idx;
    logic             rs1_stall, rs2_stall;
    logic             data_hazard;
    logic             issue, stall;
    logic [STAGES:0]  flush;

    hazard_match #(.STAGES(STAGES), .RW(RW), .IDX_W(IDX_W)) u_match_rs1 (
        .entries (sb_q),
        .src     (bus.id_rs1_i),
        .used    (bus.id_rs1_used_i),
        .hit     (rs1_hit),
        .idx     (rs1_idx),
        .is_load (rs1_ld)
    );

    hazard_match #(.STAGES(STAGES), .RW(RW), .IDX_W(IDX_W)) u_match_rs2 (
        .entries (sb_q),
        .src     (bus.id_rs2_i),
        .used    (bus.id_rs2_used_i),
        .hit     (rs2_hit),
        .idx     (rs2_idx),
        .is_load (rs2_ld)
    );

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    // Only a load still in EX cannot be bypassed; everything else forwards from its entry.
    assign rs1_stall     = rs1_hit && (rs1_idx == '0) && rs1_ld;
    assign rs2_stall     = rs2_hit && (rs2_idx == '0) && rs2_ld;
    assign bus.fwd_rs1_o = rs1_hit ? FW'(rs1_idx) + FW'(1) : '0;
    assign bus.fwd_rs2_o = rs2_hit ? FW'(rs2_idx) + FW'(1) : '0;
`else
    logic unused_match;
    assign unused_match  = ^{rs1_idx, rs2_idx, rs1_ld, rs2_ld};
    assign rs1_stall     = rs1_hit;
    assign rs2_stall     = rs2_hit;
    assign bus.fwd_rs1_o = '0;
    assign bus.fwd_rs2_o = '0;
`endif

    assign data_hazard = bus.id_valid_i && (rs1_stall || rs2_stall);

    always_comb begin
        issue = 1'b0;
        stall = 1'b0;
        flush = '0;
        if (bus.redirect_i) begin
            flush[0] = 1'b1;
            for (int k = 1; k <= RESOLVE_STAGE; k++) begin
                flush[k] = 1'b1;
            end
        end else if (bus.dmem_busy_i) begin
            stall = 1'b1;
        end else if (data_hazard) begin
            stall = 1'b1;
        end else begin
            issue = bus.id_valid_i;
        end
    end

    // Redirect kills younger entries first; a busy memory then freezes whatever survived.
    always_comb begin
        sb_kept = sb_q;
        if (bus.redirect_i) begin
            for (int k = 0; k < RESOLVE_STAGE; k++) begin
                sb_kept[k].valid = 1'b0;
            end
        end
        sb_d = sb_kept;
        if (!bus.dmem_busy_i) begin
            for (int k = 1; k < STAGES; k++) begin
                sb_d[k] = sb_kept[k-1];
            end
            sb_d[0] = issue ? make_entry(bus.id_rd_i, bus.id_rd_wr_i, bus.id_is_load_i)
                            : ENTRY_NONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q <= sb_d;
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.issue_o     = issue;
    assign bus.stall_o     = stall;
    assign bus.flush_o     = flush;
    assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and random checks of hazard_scoreboard against a queue model
module tb_hazard_scoreboard;

    localparam int STAGES = 3;
    localparam int RES    = 1;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       id_valid, u1, u2, wr, ld, redirect, busy;
    logic [4:0] rs1, rs2, rd;

    hazard_scoreboard_if #(.NUM_REGS(32), .STAGES(STAGES), .CNT_W(32)) bus ();
    hazard_scoreboard_if #(.NUM_REGS(32), .STAGES(STAGES), .CNT_W(4))  bus_s ();

    assign bus.id_valid_i      = id_valid;
    assign bus.id_rs1_i        = rs1;
    assign bus.id_rs2_i        = rs2;
    assign bus.id_rs1_used_i   = u1;
    assign bus.id_rs2_used_i   = u2;
    assign bus.id_rd_i         = rd;
    assign bus.id_rd_wr_i      = wr;
    assign bus.id_is_load_i    = ld;
    assign bus.redirect_i      = redirect;
    assign bus.dmem_busy_i     = busy;
    assign bus_s.id_valid_i    = id_valid;
    assign bus_s.id_rs1_i      = rs1;
    assign bus_s.id_rs2_i      = rs2;
    assign bus_s.id_rs1_used_i = u1;
    assign bus_s.id_rs2_used_i = u2;
    assign bus_s.id_rd_i       = rd;
    assign bus_s.id_rd_wr_i    = wr;
    assign bus_s.id_is_load_i  = ld;
    assign bus_s.redirect_i    = redirect;
    assign bus_s.dmem_busy_i   = busy;

    hazard_scoreboard #(.NUM_REGS(32), .STAGES(STAGES), .RESOLVE_STAGE(RES), .CNT_W(32)) dut (
        .clk_i(clk), .reset_n_i(rstn), .bus(bus)
    );
    hazard_scoreboard #(.NUM_REGS(32), .STAGES(STAGES), .RESOLVE_STAGE(RES), .CNT_W(4)) dut_s (
        .clk_i(clk), .reset_n_i(rstn), .bus(bus_s)
    );

    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    instr_t pipe[$];
    longint cnt_m, cnt4_m;
    bit     e_issue, e_stall;
    int     e_flush, e_fwd1, e_fwd2;
    int     checks = 0;
    int     failures = 0;

    logic       o_issue, o_stall;
    logic [3:0] o_flush;
    logic [1:0] o_fwd1, o_fwd2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int youngest(input int src, input bit used);
        for (int i = 0; i < STAGES; i++) begin
            if (pipe[i].valid && pipe[i].wr && pipe[i].rd == src && src != 0 && used) return i;
        end
        return -1;
    endfunction

    function automatic void predict();
        int y1, y2;
        bit s1, s2;
        y1 = youngest(int'(rs1), u1);
        y2 = youngest(int'(rs2), u2);
        s1 = FWD ? (y1 == 0 && pipe[0].ld) : (y1 >= 0);
        s2 = FWD ? (y2 == 0 && pipe[0].ld) : (y2 >= 0);
        e_fwd1 = (FWD && y1 >= 0) ? y1 + 1 : 0;
        e_fwd2 = (FWD && y2 >= 0) ? y2 + 1 : 0;
        e_issue = 1'b0;
        e_stall = 1'b0;
        e_flush = 0;
        if (redirect)                    e_flush = (1 << (RES + 1)) - 1;
        else if (busy)                   e_stall = 1'b1;
        else if (id_valid && (s1 || s2)) e_stall = 1'b1;
        else                             e_issue = id_valid;
    endfunction

    function automatic void update();
        instr_t t;
        t = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) pipe[i] = t;
            cnt_m  = 0;
            cnt4_m = 0;
        end else begin
            if (e_stall) begin
                if (cnt_m < 64'hFFFF_FFFF) cnt_m++;
                if (cnt4_m < 15) cnt4_m++;
            end
            if (redirect) for (int i = 0; i < RES; i++) pipe[i].valid = 1'b0;
            if (!busy) begin
                if (e_issue) t = '{valid: 1'b1, rd: int'(rd), wr: wr, ld: ld};
                void'(pipe.pop_back());
                pipe.push_front(t);
            end
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
        predict();
        o_issue = bus.issue_o;
        o_stall = bus.stall_o;
        o_flush = bus.flush_o;
        o_fwd1  = bus.fwd_rs1_o;
        o_fwd2  = bus.fwd_rs2_o;
        chk("issue", o_issue, e_issue);
        chk("stall", o_stall, e_stall);
        chk("flush", o_flush, e_flush);
        chk("fwd_rs1", o_fwd1, e_fwd1);
        chk("fwd_rs2", o_fwd2, e_fwd2);
        chk("stall_cnt", bus.stall_cnt_o, cnt_m);
        chk("stall_cnt_w4", bus_s.stall_cnt_o, cnt4_m);
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic set_id(input bit v, input int a, input bit ua, input int b, input bit ub,
                          input int d, input bit w, input bit l);
        id_valid = v;  rs1 = 5'(a); u1 = ua; rs2 = 5'(b); u2 = ub;
        rd = 5'(d);    wr = w;      ld = l;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) cycle();
    endtask

    task automatic issue_until(input string tag, input int max, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        for (int i = 0; i < max && !done; i++) begin
            cycle();
            if (o_stall === 1'b1) stalls++;
            if (o_issue === 1'b1) done = 1'b1;
        end
        chk({tag, "_issued"}, done, 1);
    endtask

    initial begin
        int     st;
        longint base;
        bit     held;

        for (int i = 0; i < STAGES; i++) pipe.push_back('{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0});
        cnt_m = 0; cnt4_m = 0;
        rstn = 1'b0; redirect = 1'b0; busy = 1'b0;
        set_id(1, 20, 1, 21, 1, 3, 1, 0);
        @(posedge clk);
        #1;
        cycle();
        chk("reset_issue", o_issue, 1);
        rstn = 1'b1;
        chk("reset_cnt", bus.stall_cnt_o, 0);

        for (int i = 1; i <= 6; i++) begin
            set_id(1, 20, 1, 21, 1, i, 1, 0);
            cycle();
            chk("indep_issue", o_issue, 1);
        end
        chk("indep_cnt", bus.stall_cnt_o, 0);
        idle(3);

        set_id(1, 0, 1, 0, 0, 5, 1, 0);
        cycle();
        set_id(1, 5, 1, 5, 1, 6, 1, 0);
        issue_until("raw", 10, st);
        chk("raw_stalls", st, FWD ? 0 : 3);
        chk("raw_fwd1", o_fwd1, FWD ? 1 : 0);
        chk("raw_fwd2", o_fwd2, FWD ? 1 : 0);
        chk("raw_cnt", bus.stall_cnt_o, FWD ? 0 : 3);
        idle(3);

        set_id(1, 0, 1, 0, 0, 7, 1, 1);
        cycle();
        set_id(1, 7, 1, 0, 1, 8, 1, 0);
        issue_until("load_use", 10, st);
        chk("load_use_stalls", st, FWD ? 1 : 3);
        chk("load_use_fwd1", o_fwd1, FWD ? 2 : 0);
        chk("load_use_cnt", bus.stall_cnt_o, FWD ? 1 : 6);
        idle(3);

        set_id(1, 0, 0, 0, 0, 9, 1, 0);
        cycle();
        set_id(1, 0, 0, 0, 0, 10, 1, 0);
        cycle();
        set_id(1, 0, 0, 0, 0, 11, 1, 0);
        redirect = 1'b1;
        cycle();
        chk("redir_flush", o_flush, 4'b0011);
        chk("redir_issue", o_issue, 0);
        redirect = 1'b0;
        set_id(1, 10, 1, 9, 1, 12, 1, 0);
        cycle();
        chk("redir_stall", o_stall, FWD ? 0 : 1);
        chk("redir_fwd1", o_fwd1, 0);
        chk("redir_fwd2", o_fwd2, FWD ? 3 : 0);
        if (o_issue !== 1'b1) issue_until("redir", 10, st);
        idle(3);

        set_id(1, 0, 0, 0, 0, 12, 1, 0);
        cycle();
        set_id(1, 12, 1, 0, 0, 13, 1, 0);
        busy = 1'b1;
        base = cnt_m;
        st = 0;
        repeat (4) begin
            cycle();
            if (o_stall === 1'b1) st++;
        end
        chk("busy_stalls", st, 4);
        chk("busy_cnt", bus.stall_cnt_o, base + 4);
        busy = 1'b0;
        issue_until("busy_release", 10, st);
        chk("busy_release_stalls", st, FWD ? 0 : 3);
        chk("busy_release_fwd1", o_fwd1, FWD ? 1 : 0);

        held = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                       $urandom_range(0, 3) != 0, 1'b0);
                ld = wr && ($urandom_range(0, 2) == 0);
            end
            redirect = ($urandom_range(0, 9) == 0);
            busy     = ($urandom_range(0, 7) == 0);
            cycle();
            held = id_valid && (o_issue !== 1'b1) && !redirect;
        end
        redirect = 1'b0;
        busy     = 1'b0;

        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        busy = 1'b1;
        repeat (14) cycle();
        chk("sat_pre", bus_s.stall_cnt_o, 14);
        repeat (3) cycle();
        chk("sat_stick", bus_s.stall_cnt_o, 15);
        chk("sat_wide", bus.stall_cnt_o, 17);
        busy = 1'b0;
        idle(3);

        set_id(1, 0, 0, 0, 0, 14, 1, 1);
        cycle();
        set_id(1, 14, 1, 0, 0, 15, 1, 0);
        cycle();
        chk("midstall_stall", o_stall, 1);
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        chk("midstall_rst_cnt", bus.stall_cnt_o, 0);
        chk("midstall_rst_cnt_w4", bus_s.stall_cnt_o, 0);
        cycle();
        chk("midstall_rst_issue", o_issue, 1);
        chk("midstall_rst_nostall", o_stall, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
